// File: rtl/vout_scan_ctrl_pkg.sv
// Shared definitions for the output-scan controller: default widths, unity weight
// and the scan FSM state encoding.
package vout_scale_pkg;

  localparam int unsigned CW_DEF   = 16;
  localparam int unsigned FRAC_DEF = 16;

  localparam logic [FRAC_DEF:0] ONE = {1'b1, {FRAC_DEF{1'b0}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ROW = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } scan_state_e;

endpackage

// File: rtl/vout_scan_ctrl_coef.sv
// Bilinear weight generator: one fx*fy product per beat, registered, held while stalled.
// The four weights always sum to exactly 1.0 because coef1 absorbs the truncation of p.
module vout_coef_calc
  import vout_scale_pkg::*;
#(
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [FRAC-1:0] fx_i,
  input  logic [FRAC-1:0] fy_i,
  output logic [FRAC:0]   coef1_o,
  output logic [FRAC:0]   coef2_o,
  output logic [FRAC:0]   coef3_o,
  output logic [FRAC:0]   coef4_o
);

  localparam logic [FRAC:0] ONE_C = {1'b1, {FRAC{1'b0}}};

  logic [2*FRAC-1:0] prod_s;
  logic [FRAC:0]     p_s, fx_s, fy_s;
  logic [FRAC:0]     coef1_d, coef2_d, coef3_d, coef4_d;
  logic [FRAC:0]     coef1_q, coef2_q, coef3_q, coef4_q;

  // Intermediate wrap in coef1 is harmless: the true result always lies in [0, 1.0].
  always_comb begin
    prod_s  = {{FRAC{1'b0}}, fx_i} * {{FRAC{1'b0}}, fy_i};
    p_s     = {1'b0, prod_s[2*FRAC-1:FRAC]};
    fx_s    = {1'b0, fx_i};
    fy_s    = {1'b0, fy_i};
    coef4_d = p_s;
    coef2_d = fx_s - p_s;
    coef3_d = fy_s - p_s;
    coef1_d = ONE_C - fx_s - fy_s + p_s;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      coef1_q <= {(FRAC+1){1'b0}};
      coef2_q <= {(FRAC+1){1'b0}};
      coef3_q <= {(FRAC+1){1'b0}};
      coef4_q <= {(FRAC+1){1'b0}};
    end else if (clr_i) begin
      coef1_q <= {(FRAC+1){1'b0}};
      coef2_q <= {(FRAC+1){1'b0}};
      coef3_q <= {(FRAC+1){1'b0}};
      coef4_q <= {(FRAC+1){1'b0}};
    end else if (en_i) begin
      coef1_q <= coef1_d;
      coef2_q <= coef2_d;
      coef3_q <= coef3_d;
      coef4_q <= coef4_d;
    end
  end

  assign coef1_o = coef1_q;
  assign coef2_o = coef2_q;
  assign coef3_o = coef3_q;
  assign coef4_o = coef4_q;

endmodule

// File: rtl/vout_scan_ctrl.sv
// Output-raster scan controller: DDA source mapping, edge clamp, input-row gating and a
// two-stage valid/ready pipeline feeding the bilinear interpolator.
module vout_scan_ctrl
  import vout_scale_pkg::*;
#(
  parameter int unsigned CW   = CW_DEF,
  parameter int unsigned FRAC = FRAC_DEF,
  parameter int unsigned LEAD = 1
) (
  input  logic               vin_clk,
  input  logic               rst_n,
  input  logic               frame_sync_n,
  input  logic [CW-1:0]      vin_row,
  input  logic [CW-1:0]      vin_xres,
  input  logic [CW-1:0]      vin_yres,
  input  logic [CW-1:0]      vout_xres,
  input  logic [CW-1:0]      vout_yres,
  input  logic [CW+FRAC-1:0] x_step,
  input  logic [CW+FRAC-1:0] y_step,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof,
  output logic [CW-1:0]      src_x,
  output logic [CW-1:0]      src_y,
  output logic [FRAC-1:0]    frac_x,
  output logic [FRAC-1:0]    frac_y,
  output logic [FRAC:0]      coef1,
  output logic [FRAC:0]      coef2,
  output logic [FRAC:0]      coef3,
  output logic [FRAC:0]      coef4,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned   AW      = CW + FRAC;
  localparam logic [CW-1:0] ZERO_CW = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CW  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ZERO_AW = {AW{1'b0}};

  scan_state_e     state_q, state_d;
  logic [CW-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic [AW-1:0]   x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic            advance_s, issue_s, row_last_s, frame_last_s;

  // A row may run once the lower bilinear neighbour (LEAD rows on) is in the line buffer.
  function automatic logic row_avail(input logic [AW-1:0] acc, input logic [CW-1:0] row,
                                     input logic [CW-1:0] yres);
    logic [CW:0] need, last;
    need = {1'b0, acc[AW-1:FRAC]} + (CW+1)'(LEAD);
    last = {1'b0, yres} - {{CW{1'b0}}, 1'b1};
    if (need > last) need = last;
    return ({1'b0, row} > need) || (row >= yres);
  endfunction

  assign advance_s    = ~out_valid | out_ready;
  assign issue_s      = (state_q == RUN) && advance_s;
  assign row_last_s   = (ox_q == vout_xres - ONE_CW);
  assign frame_last_s = (oy_q == vout_yres - ONE_CW);

  // Next-state, raster counters and DDA accumulators; the next row is pre-checked so an
  // already-available row continues without a bubble.
  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    x_acc_d = x_acc_q;
    y_acc_d = y_acc_q;
    if (!frame_sync_n) begin
      state_d = IDLE;
      ox_d    = ZERO_CW;
      oy_d    = ZERO_CW;
      x_acc_d = ZERO_AW;
      y_acc_d = ZERO_AW;
    end else begin
      case (state_q)
        IDLE: begin
          if ((vout_xres != ZERO_CW) && (vout_yres != ZERO_CW)) state_d = WAIT_ROW;
          else                                                  state_d = IDLE;
        end
        WAIT_ROW: begin
          if (row_avail(y_acc_q, vin_row, vin_yres)) state_d = RUN;
          else                                       state_d = WAIT_ROW;
        end
        RUN: begin
          if (issue_s && row_last_s) begin
            ox_d    = ZERO_CW;
            x_acc_d = ZERO_AW;
            oy_d    = oy_q + ONE_CW;
            y_acc_d = y_acc_q + y_step;
            if (frame_last_s)                                    state_d = DONE;
            else if (row_avail(y_acc_q + y_step, vin_row, vin_yres)) state_d = RUN;
            else                                                 state_d = WAIT_ROW;
          end else if (issue_s) begin
            ox_d    = ox_q + ONE_CW;
            x_acc_d = x_acc_q + x_step;
          end else begin
            state_d = RUN;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ox_q    <= ZERO_CW;
      oy_q    <= ZERO_CW;
      x_acc_q <= ZERO_AW;
      y_acc_q <= ZERO_AW;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      x_acc_q <= x_acc_d;
      y_acc_q <= y_acc_d;
    end
  end

  logic [CW-1:0]   x_int_s, y_int_s, x_last_s, y_last_s, sx_s, sy_s;
  logic [FRAC-1:0] fx_s, fy_s;

  // Edge replicate: past the last source pixel the weight collapses onto that pixel.
  always_comb begin
    x_int_s  = x_acc_q[AW-1:FRAC];
    y_int_s  = y_acc_q[AW-1:FRAC];
    x_last_s = vin_xres - ONE_CW;
    y_last_s = vin_yres - ONE_CW;
    if (x_int_s >= x_last_s) begin
      sx_s = x_last_s;
      fx_s = {FRAC{1'b0}};
    end else begin
      sx_s = x_int_s;
      fx_s = x_acc_q[FRAC-1:0];
    end
    if (y_int_s >= y_last_s) begin
      sy_s = y_last_s;
      fy_s = {FRAC{1'b0}};
    end else begin
      sy_s = y_int_s;
      fy_s = y_acc_q[FRAC-1:0];
    end
  end

  logic            s1_valid_q, s1_sof_q, s1_eol_q, s1_eof_q;
  logic [CW-1:0]   s1_sx_q, s1_sy_q;
  logic [FRAC-1:0] s1_fx_q, s1_fy_q;

  // Both stages move together on advance; everything freezes under backpressure.
  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n || !frame_sync_n) begin
      {s1_valid_q, s1_sof_q, s1_eol_q, s1_eof_q} <= 4'b0000;
      {s1_sx_q, s1_sy_q}                         <= {2*CW{1'b0}};
      {s1_fx_q, s1_fy_q}                         <= {2*FRAC{1'b0}};
      {out_valid, out_sof, out_eol, out_eof}     <= 4'b0000;
      {src_x, src_y}                             <= {2*CW{1'b0}};
      {frac_x, frac_y}                           <= {2*FRAC{1'b0}};
    end else if (advance_s) begin
      s1_valid_q <= issue_s;
      if (issue_s) begin
        s1_sof_q <= (ox_q == ZERO_CW) && (oy_q == ZERO_CW);
        s1_eol_q <= row_last_s;
        s1_eof_q <= row_last_s && frame_last_s;
        s1_sx_q  <= sx_s;
        s1_sy_q  <= sy_s;
        s1_fx_q  <= fx_s;
        s1_fy_q  <= fy_s;
      end
      out_valid <= s1_valid_q;
      out_sof   <= s1_sof_q;
      out_eol   <= s1_eol_q;
      out_eof   <= s1_eof_q;
      src_x     <= s1_sx_q;
      src_y     <= s1_sy_q;
      frac_x    <= s1_fx_q;
      frac_y    <= s1_fy_q;
    end
  end

  vout_coef_calc #(.FRAC(FRAC)) u_coef (
    .clk_i   (vin_clk),
    .rst_n_i (rst_n),
    .clr_i   (~frame_sync_n),
    .en_i    (advance_s),
    .fx_i    (s1_fx_q),
    .fy_i    (s1_fy_q),
    .coef1_o (coef1),
    .coef2_o (coef2),
    .coef3_o (coef3),
    .coef4_o (coef4)
  );

  assign busy       = (state_q == WAIT_ROW) || (state_q == RUN);
  assign frame_done = out_valid & out_ready & out_eof;

endmodule

// File: tb/tb_vout_scan_ctrl.sv
// Directed bench for vout_scan_ctrl: table of hand-computed beats per configuration,
// full-frame model comparison, plus row-gating, backpressure and frame-abort sequences.
module tb_vout_scan_ctrl;
  import vout_scale_pkg::*;

  typedef struct packed {
    logic sof; logic eol; logic eof;
    logic [15:0] sx; logic [15:0] sy; logic [15:0] fx; logic [15:0] fy;
    logic [16:0] c1; logic [16:0] c2; logic [16:0] c3; logic [16:0] c4;
  } beat_t;
  typedef struct { int vxr; int vyr; int oxr; int oyr; int xs; int ys; } cfg_t;
  typedef struct { int c; int idx; beat_t exp; } vec_t;

  logic        vin_clk, rst_n, frame_sync_n, out_ready;
  logic [15:0] vin_row, vin_xres, vin_yres, vout_xres, vout_yres;
  logic [31:0] x_step, y_step;
  logic        out_valid, out_sof, out_eol, out_eof, busy, frame_done;
  logic [15:0] src_x, src_y, frac_x, frac_y;
  logic [16:0] coef1, coef2, coef3, coef4;

  vout_scan_ctrl dut (
    .vin_clk(vin_clk), .rst_n(rst_n), .frame_sync_n(frame_sync_n), .vin_row(vin_row),
    .vin_xres(vin_xres), .vin_yres(vin_yres), .vout_xres(vout_xres), .vout_yres(vout_yres),
    .x_step(x_step), .y_step(y_step), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .src_x(src_x), .src_y(src_y),
    .frac_x(frac_x), .frac_y(frac_y), .coef1(coef1), .coef2(coef2), .coef3(coef3),
    .coef4(coef4), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    vin_clk = 1'b0;
    forever #5 vin_clk = ~vin_clk;
  end

  int ntests = 0;
  int nfail  = 0;
  int ready_mode = 0;
  int fd_cnt = 0;
  int fd_base;
  cfg_t  cfgs[4];
  vec_t  vecs[12];
  beat_t beats[$];
  beat_t cur_s, held_q;
  logic  stall_q = 1'b0;

  assign cur_s = {out_sof, out_eol, out_eof, src_x, src_y, frac_x, frac_y,
                  coef1, coef2, coef3, coef4};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input int sof, input int eol, input int eof, input int sx,
                               input int sy, input int fx, input int fy, input int c1,
                               input int c2, input int c3, input int c4);
    beat_t b;
    b = {1'(sof), 1'(eol), 1'(eof), 16'(sx), 16'(sy), 16'(fx), 16'(fy),
         17'(c1), 17'(c2), 17'(c3), 17'(c4)};
    return b;
  endfunction

  // Reference from the mapping formulas, position computed as ox*step (no accumulation).
  function automatic beat_t model(input int c, input int ox, input int oy);
    longint ax, ay, ix, iy, fx, fy, p;
    ax = longint'(ox) * longint'(cfgs[c].xs);
    ay = longint'(oy) * longint'(cfgs[c].ys);
    ix = ax / 65536; fx = ax % 65536;
    iy = ay / 65536; fy = ay % 65536;
    if (ix >= cfgs[c].vxr - 1) begin ix = cfgs[c].vxr - 1; fx = 0; end
    if (iy >= cfgs[c].vyr - 1) begin iy = cfgs[c].vyr - 1; fy = 0; end
    p = (fx * fy) / 65536;
    return mk(int'(ox == 0 && oy == 0), int'(ox == cfgs[c].oxr - 1),
              int'(ox == cfgs[c].oxr - 1 && oy == cfgs[c].oyr - 1),
              int'(ix), int'(iy), int'(fx), int'(fy),
              int'(65536 - fx - fy + p), int'(fx - p), int'(fy - p), int'(p));
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge vin_clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else                 out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge vin_clk) begin
    if (stall_q) chk("stall_hold", {out_valid, cur_s}, {1'b1, held_q});
    if (frame_done) chk("done_on_eof_accept", {out_valid, out_ready, out_eof}, 3'b111);
    if (out_valid && out_ready) beats.push_back(cur_s);
    if (frame_done) fd_cnt <= fd_cnt + 1;
    stall_q <= out_valid && !out_ready && rst_n && frame_sync_n;
    held_q  <= cur_s;
  end

  task automatic start_frame(input int c, input int rmode, input int row);
    @(posedge vin_clk); #1;
    frame_sync_n = 1'b0;
    vin_xres  = 16'(cfgs[c].vxr); vin_yres  = 16'(cfgs[c].vyr);
    vout_xres = 16'(cfgs[c].oxr); vout_yres = 16'(cfgs[c].oyr);
    x_step    = 32'(cfgs[c].xs);  y_step    = 32'(cfgs[c].ys);
    vin_row   = 16'(row);
    ready_mode = rmode;
    repeat (2) @(posedge vin_clk); #1;
    beats.delete();
    fd_base = fd_cnt;
    frame_sync_n = 1'b1;
  endtask

  task automatic finish_frame(input int c);
    int n;
    for (int i = 0; i < 3000 && fd_cnt == fd_base; i++) @(posedge vin_clk);
    repeat (6) @(posedge vin_clk);
    @(negedge vin_clk);
    n = cfgs[c].oxr * cfgs[c].oyr;
    chk("frame_done_once", 160'(fd_cnt - fd_base), 160'(1));
    chk("beat_count", 160'(beats.size()), 160'(n));
    chk("done_idle_outputs", {busy, out_valid}, 2'b00);
    for (int i = 0; i < beats.size() && i < n; i++)
      chk("beat_vs_model", beats[i], model(c, i % cfgs[c].oxr, i / cfgs[c].oxr));
    ready_mode = 0;
  endtask

  initial begin
    cfgs[0] = '{4, 4, 4, 4, 32'h10000, 32'h10000};
    cfgs[1] = '{8, 8, 4, 4, 32'h20000, 32'h20000};
    cfgs[2] = '{2, 4, 4, 4, 32'h08000, 32'h10000};
    cfgs[3] = '{3, 3, 4, 4, 32'h0C000, 32'h0C000};
    vecs[0]  = '{0, 0,  mk(1,0,0, 0,0, 0,0, 65536,0,0,0)};
    vecs[1]  = '{0, 5,  mk(0,0,0, 1,1, 0,0, 65536,0,0,0)};
    vecs[2]  = '{0, 15, mk(0,1,1, 3,3, 0,0, 65536,0,0,0)};
    vecs[3]  = '{1, 3,  mk(0,1,0, 6,0, 0,0, 65536,0,0,0)};
    vecs[4]  = '{1, 9,  mk(0,0,0, 2,4, 0,0, 65536,0,0,0)};
    vecs[5]  = '{1, 15, mk(0,1,1, 6,6, 0,0, 65536,0,0,0)};
    vecs[6]  = '{2, 1,  mk(0,0,0, 0,0, 'h8000,0, 'h8000,'h8000,0,0)};
    vecs[7]  = '{2, 2,  mk(0,0,0, 1,0, 0,0, 65536,0,0,0)};
    vecs[8]  = '{2, 7,  mk(0,1,0, 1,1, 0,0, 65536,0,0,0)};
    vecs[9]  = '{3, 5,  mk(0,0,0, 0,0, 'hC000,'hC000, 'h1000,'h3000,'h3000,'h9000)};
    vecs[10] = '{3, 6,  mk(0,0,0, 1,0, 'h8000,'hC000, 'h2000,'h2000,'h6000,'h6000)};
    vecs[11] = '{3, 9,  mk(0,0,0, 0,1, 'hC000,'h8000, 'h2000,'h6000,'h2000,'h6000)};

    rst_n = 1'b0; frame_sync_n = 1'b0; vin_row = 16'd0;
    vin_xres = 16'd4; vin_yres = 16'd4; vout_xres = 16'd0; vout_yres = 16'd4;
    x_step = 32'h10000; y_step = 32'h10000;
    repeat (3) @(posedge vin_clk);
    @(negedge vin_clk);
    chk("reset_state", {out_valid, busy, frame_done, cur_s}, 160'(0));
    rst_n = 1'b1;

    // Zero output width keeps the block idle even with frame_sync_n high.
    @(posedge vin_clk); #1;
    vin_row = 16'd4; frame_sync_n = 1'b1;
    repeat (10) @(posedge vin_clk);
    @(negedge vin_clk);
    chk("zero_size_idle", {busy, out_valid, 16'(beats.size())}, 160'(0));

    for (int c = 0; c < 4; c++) begin
      start_frame(c, 0, cfgs[c].vyr);
      finish_frame(c);
      for (int v = 0; v < 12; v++) begin
        if (vecs[v].c == c) begin
          if (vecs[v].idx < beats.size()) chk("table_beat", beats[vecs[v].idx], vecs[v].exp);
          else chk("table_beat_missing", 160'(beats.size()), 160'(vecs[v].idx + 1));
        end
      end
    end

    // Random backpressure: same beat stream, held outputs checked by the monitor.
    start_frame(3, 1, 3);
    finish_frame(3);
    start_frame(1, 1, 8);
    finish_frame(1);

    // Row gating: nothing without rows, then exactly row 0 with two rows written.
    start_frame(0, 0, 0);
    repeat (20) @(posedge vin_clk);
    @(negedge vin_clk);
    chk("gate_no_beats", {out_valid, 16'(beats.size())}, 160'(0));
    chk("gate_busy", busy, 1'b1);
    @(posedge vin_clk); #1;
    vin_row = 16'd2;
    repeat (30) @(posedge vin_clk);
    @(negedge vin_clk);
    chk("gate_row0_only", {busy, 16'(beats.size())}, {1'b1, 16'd4});
    @(posedge vin_clk); #1;
    vin_row = 16'd4;
    finish_frame(0);

    // Frame abort mid-row, then a clean restart from (0,0).
    start_frame(0, 0, 4);
    for (int i = 0; i < 200 && beats.size() < 6; i++) @(posedge vin_clk);
    chk("abort_reached_mid_row", 160'(beats.size() >= 6), 160'(1));
    @(posedge vin_clk); #1;
    frame_sync_n = 1'b0;
    @(posedge vin_clk);
    @(negedge vin_clk);
    chk("abort_clear", {out_valid, busy, frame_done, cur_s}, 160'(0));
    @(posedge vin_clk); #1;
    beats.delete();
    fd_base = fd_cnt;
    frame_sync_n = 1'b1;
    finish_frame(0);
    if (beats.size() > 0) chk("restart_sof", {beats[0].sof, beats[0].sx, beats[0].sy}, {1'b1, 32'd0});
    else chk("restart_no_beats", 160'(beats.size()), 160'(16));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
